cam_access_controller: RTL and testbench

//  Sequences all accesses to the CAM array (CAM_Array_st): owns the array's write-enable, search_word and dont_care_mask pins.

---
 rtl/cam_ctrl_pkg.sv | 21 ++
 rtl/cam_priority_encoder.sv | 28 ++
 rtl/cam_access_controller.sv | 150 +++++++++++++++
 tb/tb_cam_access_controller.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_ctrl_pkg.sv
// Shared types and helpers for the CAM access controller and its priority encoder.
package cam_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        SEARCH,
        RESULT
    } cam_state_e;

    typedef enum logic {
        GRANT_WR,
        GRANT_SRCH
    } cam_grant_e;

    // Index width for a given row count; never narrower than one bit.
    function automatic int unsigned CAM_IDX_W(input int unsigned depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/cam_priority_encoder.sv
// Combinational encoder for the CAM match vector: any-hit flag, multi-hit flag and
// index of the lowest matching row (0 when nothing matched).
module cam_priority_encoder
    import cam_ctrl_pkg::*;
#(
    parameter int unsigned CAM_DEPTH = 8
) (
    input  logic [CAM_DEPTH-1:0]                vec,
    output logic                                hit,
    output logic                                multi,
    output logic [CAM_IDX_W(CAM_DEPTH)-1:0]     index
);

    localparam int unsigned IDX_W = CAM_IDX_W(CAM_DEPTH);

    // Clearing the lowest set bit leaves something behind only when two or more were set.
    always_comb begin
        hit   = |vec;
        multi = (vec & (vec - CAM_DEPTH'(1))) != '0;
        index = '0;
        for (int i = int'(CAM_DEPTH) - 1; i >= 0; i--) begin
            if (vec[i]) begin
                index = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/cam_access_controller.sv
// Sequences writes and searches onto an external CAM array and returns encoded results.
// Optional per-row valid tracking is enabled with `define CAM_VALID_TRACK_EN.
module cam_access_controller
    import cam_ctrl_pkg::*;
#(
    parameter int unsigned CAM_DEPTH  = 8,
    parameter int unsigned CAM_WIDTH  = 8,
    parameter int unsigned SEARCH_LAT = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                wr_valid,
    output logic                                wr_ready,
    input  logic [CAM_IDX_W(CAM_DEPTH)-1:0]     wr_addr,
    input  logic [CAM_WIDTH-1:0]                wr_data,
    input  logic [CAM_WIDTH-1:0]                wr_mask,
    input  logic                                srch_valid,
    output logic                                srch_ready,
    input  logic [CAM_WIDTH-1:0]                srch_key,
    input  logic [CAM_WIDTH-1:0]                srch_mask,
    output logic                                res_valid,
    input  logic                                res_ready,
    output logic                                res_hit,
    output logic                                res_multi,
    output logic [CAM_IDX_W(CAM_DEPTH)-1:0]     res_index,
    output logic [CAM_DEPTH-1:0]                cam_we_row,
    output logic [CAM_WIDTH-1:0]                cam_search_word,
    output logic [CAM_WIDTH-1:0]                cam_dont_care_mask,
    input  logic [CAM_DEPTH-1:0]                cam_match_vec
);

    localparam int unsigned IDX_W = CAM_IDX_W(CAM_DEPTH);
    localparam int unsigned CNT_W = 4;

    cam_state_e             state;
    cam_grant_e             last_grant;
    logic [CNT_W-1:0]       lat_cnt;
    logic [CAM_DEPTH-1:0]   match_q;
    logic [CAM_DEPTH-1:0]   we_next;
    logic [CAM_DEPTH-1:0]   valid_gate;
    logic                   grant_wr;
    logic                   grant_srch;

    // Round-robin arbitration in IDLE; held low during reset so every output reads 0.
    always_comb begin
        wr_ready   = 1'b0;
        srch_ready = 1'b0;
        if (rst && state == IDLE) begin
            if (wr_valid && (!srch_valid || last_grant == GRANT_SRCH)) begin
                wr_ready = 1'b1;
            end else if (srch_valid) begin
                srch_ready = 1'b1;
            end
        end
    end

    assign grant_wr   = wr_valid & wr_ready;
    assign grant_srch = srch_valid & srch_ready;

    // Addresses beyond the array decode to no row, so such writes touch nothing.
    always_comb begin
        we_next = '0;
        for (int i = 0; i < int'(CAM_DEPTH); i++) begin
            we_next[i] = (wr_addr == IDX_W'(i));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state              <= IDLE;
            last_grant         <= GRANT_SRCH;
            lat_cnt            <= '0;
            match_q            <= '0;
            res_valid          <= 1'b0;
            cam_we_row         <= '0;
            cam_search_word    <= '0;
            cam_dont_care_mask <= '0;
        end else begin
            cam_we_row <= '0;
            case (state)
                IDLE: begin
                    if (grant_wr) begin
                        cam_we_row         <= we_next;
                        cam_search_word    <= wr_data;
                        cam_dont_care_mask <= wr_mask;
                        last_grant         <= GRANT_WR;
                        state              <= WRITE;
                    end else if (grant_srch) begin
                        cam_search_word    <= srch_key;
                        cam_dont_care_mask <= srch_mask;
                        lat_cnt            <= '0;
                        last_grant         <= GRANT_SRCH;
                        state              <= SEARCH;
                    end
                end
                WRITE: begin
                    state <= IDLE;
                end
                SEARCH: begin
                    lat_cnt <= lat_cnt + CNT_W'(1);
                    if (lat_cnt == CNT_W'(SEARCH_LAT - 1)) begin
                        match_q   <= cam_match_vec & valid_gate;
                        res_valid <= 1'b1;
                        state     <= RESULT;
                    end
                end
                RESULT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef CAM_VALID_TRACK_EN
    logic [CAM_DEPTH-1:0] row_valid;

    // A write with an all-ones mask can never mismatch, so it is treated as an invalidate.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_valid <= '0;
        end else if (grant_wr) begin
            for (int i = 0; i < int'(CAM_DEPTH); i++) begin
                if (we_next[i]) begin
                    row_valid[i] <= (wr_mask != '1);
                end
            end
        end
    end

    assign valid_gate = row_valid;
`else
    assign valid_gate = '1;
`endif

    cam_priority_encoder #(
        .CAM_DEPTH (CAM_DEPTH)
    ) u_encoder (
        .vec   (match_q),
        .hit   (res_hit),
        .multi (res_multi),
        .index (res_index)
    );

endmodule

// File: tb/tb_cam_access_controller.sv
// Self-checking bench for cam_access_controller: emulates the CAM array and compares
// results against a row-table reference model (honours CAM_VALID_TRACK_EN).
module tb_cam_access_controller;

    localparam int DEPTH = 8;
    localparam int WIDTH = 8;
    localparam int LAT   = 2;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               wr_valid = 1'b0;
    logic               wr_ready;
    logic [2:0]         wr_addr = '0;
    logic [WIDTH-1:0]   wr_data = '0;
    logic [WIDTH-1:0]   wr_mask = '0;
    logic               srch_valid = 1'b0;
    logic               srch_ready;
    logic [WIDTH-1:0]   srch_key = '0;
    logic [WIDTH-1:0]   srch_mask = '0;
    logic               res_valid;
    logic               res_ready = 1'b0;
    logic               res_hit;
    logic               res_multi;
    logic [2:0]         res_index;
    logic [DEPTH-1:0]   cam_we_row;
    logic [WIDTH-1:0]   cam_search_word;
    logic [WIDTH-1:0]   cam_dont_care_mask;
    logic [DEPTH-1:0]   cam_match_vec;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cam_access_controller #(
        .CAM_DEPTH  (DEPTH),
        .CAM_WIDTH  (WIDTH),
        .SEARCH_LAT (LAT)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .wr_valid           (wr_valid),
        .wr_ready           (wr_ready),
        .wr_addr            (wr_addr),
        .wr_data            (wr_data),
        .wr_mask            (wr_mask),
        .srch_valid         (srch_valid),
        .srch_ready         (srch_ready),
        .srch_key           (srch_key),
        .srch_mask          (srch_mask),
        .res_valid          (res_valid),
        .res_ready          (res_ready),
        .res_hit            (res_hit),
        .res_multi          (res_multi),
        .res_index          (res_index),
        .cam_we_row         (cam_we_row),
        .cam_search_word    (cam_search_word),
        .cam_dont_care_mask (cam_dont_care_mask),
        .cam_match_vec      (cam_match_vec)
    );

    // Behavioural CAM array: rows written on the clock edge, combinational lookup.
    logic [WIDTH-1:0] arrWord [DEPTH] = '{8'h80, 8'h81, 8'h82, 8'h83, 8'h84, 8'h85, 8'h86, 8'h87};
    logic [WIDTH-1:0] arrMask [DEPTH] = '{default: 8'h00};

    always @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (cam_we_row[i]) begin
                arrWord[i] <= cam_search_word;
                arrMask[i] <= cam_dont_care_mask;
            end
        end
    end

    always_comb begin
        cam_match_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cam_match_vec[i] = (((arrWord[i] ^ cam_search_word) & ~arrMask[i] & ~cam_dont_care_mask) == 8'h00);
        end
    end

    // Reference model: the table of rows the bench believes it has written.
    logic [WIDTH-1:0] mWord [DEPTH];
    logic [WIDTH-1:0] mMask [DEPTH];
    bit               mValid [DEPTH];
    logic             expHit;
    logic             expMulti;
    logic [2:0]       expIdx;
    bit               lastGrantWasWrite = 1'b0;

    logic [4:0]       expQ [$];
    logic [4:0]       expEntry;
    logic [WIDTH-1:0] dataTab [4] = '{8'hA5, 8'h3C, 8'h11, 8'h00};
    logic [WIDTH-1:0] rndData;
    logic [WIDTH-1:0] rndMask;
    int               rndSel;
    int               grants;
    int               cyc;
    bit               expWrite;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic modelWrite(input logic [2:0] a, input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] m);
        mWord[a] = d;
        mMask[a] = m;
        mValid[a] = (m != 8'hFF);
    endtask

    task automatic modelReset();
        for (int i = 0; i < DEPTH; i++) mValid[i] = 1'b0;
    endtask

    // A row matches when every bit either agrees or is a don't-care on either side.
    task automatic modelSearch(input logic [WIDTH-1:0] key, input logic [WIDTH-1:0] smask);
        int  count;
        bit  rowMatch;
        count  = 0;
        expIdx = 3'd0;
        for (int i = 0; i < DEPTH; i++) begin
            rowMatch = (((mWord[i] ~^ key) | mMask[i] | smask) == 8'hFF);
`ifdef CAM_VALID_TRACK_EN
            rowMatch = rowMatch && mValid[i];
`endif
            if (rowMatch) begin
                if (count == 0) expIdx = 3'(i);
                count++;
            end
        end
        expHit   = (count > 0);
        expMulti = (count > 1);
    endtask

    // Presents one request and holds it until the DUT accepts it.
    task automatic applyStimulus(input bit isWrite, input logic [2:0] addr,
                                 input logic [WIDTH-1:0] word, input logic [WIDTH-1:0] mask);
        int waited;
        @(negedge clk);
        if (isWrite) begin
            wr_valid = 1'b1; wr_addr = addr; wr_data = word; wr_mask = mask;
        end else begin
            srch_valid = 1'b1; srch_key = word; srch_mask = mask;
        end
        #1;
        waited = 0;
        while (!(isWrite ? wr_ready : srch_ready) && waited < 50) begin
            @(negedge clk); #1; waited++;
        end
        if (isWrite) begin
            checkOutput("wr_grant", 32'(waited < 50), 32'd1);
            modelWrite(addr, word, mask);
            lastGrantWasWrite = 1'b1;
            @(negedge clk);
            wr_valid = 1'b0;
            checkOutput("we_row", 32'(cam_we_row), 32'd1 << addr);
            checkOutput("we_word", 32'(cam_search_word), 32'(word));
            checkOutput("we_mask", 32'(cam_dont_care_mask), 32'(mask));
            @(negedge clk);
            checkOutput("we_clear", 32'(cam_we_row), 32'd0);
        end else begin
            checkOutput("srch_grant", 32'(waited < 50), 32'd1);
            modelSearch(word, mask);
            lastGrantWasWrite = 1'b0;
        end
    endtask

    task automatic waitResult(input int stall);
        int lat;
        lat = 0;
        do begin
            @(negedge clk);
            srch_valid = 1'b0;
            lat++;
        end while (!res_valid && lat < 50);
        checkOutput("srch_latency", 32'(lat), 32'(LAT + 1));
        checkOutput("res_hit", 32'(res_hit), 32'(expHit));
        checkOutput("res_multi", 32'(res_multi), 32'(expMulti));
        checkOutput("res_index", 32'(res_index), 32'(expIdx));
        repeat (stall) @(negedge clk);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        checkOutput("res_release", 32'(res_valid), 32'd0);
    endtask

    always @(negedge clk) begin
        if (rst && (wr_ready || srch_ready)) begin
            checkOutput("ready_excl", 32'(wr_ready & srch_ready), 32'd0);
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL global_timeout: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mWord[i]  = 8'h80 + 8'(i);
            mMask[i]  = 8'h00;
            mValid[i] = 1'b0;
        end

        // Reset state, with requests present to show they are ignored.
        wr_valid = 1'b1; srch_valid = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("rst_wr_ready", 32'(wr_ready), 32'd0);
        checkOutput("rst_srch_ready", 32'(srch_ready), 32'd0);
        checkOutput("rst_res_valid", 32'(res_valid), 32'd0);
        checkOutput("rst_res_bits", 32'({res_hit, res_multi, res_index}), 32'd0);
        checkOutput("rst_we_row", 32'(cam_we_row), 32'd0);
        checkOutput("rst_word", 32'(cam_search_word), 32'd0);
        checkOutput("rst_mask", 32'(cam_dont_care_mask), 32'd0);
        wr_valid = 1'b0; srch_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // Single hit, then a multi-hit, then a miss.
        applyStimulus(1'b1, 3'd3, 8'hA5, 8'h00);
        applyStimulus(1'b0, 3'd0, 8'hA5, 8'h00);
        waitResult(0);
        applyStimulus(1'b1, 3'd2, 8'h3C, 8'h00);
        applyStimulus(1'b1, 3'd5, 8'h3C, 8'h00);
        applyStimulus(1'b0, 3'd0, 8'h3C, 8'h00);
        waitResult(1);
        applyStimulus(1'b0, 3'd0, 8'h00, 8'h00);
        waitResult(2);

        // Both requesters continuously valid: grants must alternate.
        @(negedge clk);
        wr_valid = 1'b1; wr_addr = 3'd6; wr_data = 8'h77; wr_mask = 8'h00;
        srch_valid = 1'b1; srch_key = 8'h77; srch_mask = 8'h00;
        res_ready = 1'b1;
        grants = 0; cyc = 0;
        while (grants < 4 && cyc < 200) begin
            #1;
            if (res_valid && expQ.size() > 0) begin
                expEntry = expQ.pop_front();
                checkOutput("arb_res", 32'({res_hit, res_multi, res_index}), 32'(expEntry));
            end
            if (wr_ready || srch_ready) begin
                expWrite = !lastGrantWasWrite;
                checkOutput("arb_order", 32'(wr_ready), 32'(expWrite));
                if (wr_ready) begin
                    modelWrite(3'd6, 8'h77, 8'h00);
                    lastGrantWasWrite = 1'b1;
                end else begin
                    modelSearch(8'h77, 8'h00);
                    expQ.push_back({expHit, expMulti, expIdx});
                    lastGrantWasWrite = 1'b0;
                end
                grants++;
            end
            @(negedge clk);
            cyc++;
        end
        checkOutput("arb_grants", 32'(grants), 32'd4);
        wr_valid = 1'b0; srch_valid = 1'b0;
        cyc = 0;
        while (expQ.size() > 0 && cyc < 50) begin
            if (res_valid) begin
                expEntry = expQ.pop_front();
                checkOutput("arb_res", 32'({res_hit, res_multi, res_index}), 32'(expEntry));
            end
            @(negedge clk);
            cyc++;
        end
        checkOutput("arb_drain", 32'(expQ.size()), 32'd0);
        res_ready = 1'b0;

        // Consumer stalls: result must hold and no new search may be accepted.
        applyStimulus(1'b0, 3'd0, 8'hA5, 8'h00);
        cyc = 0;
        do begin
            @(negedge clk);
            srch_valid = 1'b0;
            cyc++;
        end while (!res_valid && cyc < 50);
        srch_valid = 1'b1; srch_key = 8'h3C; srch_mask = 8'h00;
        repeat (5) begin
            #1;
            checkOutput("stall_srch_ready", 32'(srch_ready), 32'd0);
            checkOutput("stall_res", 32'({res_valid, res_hit, res_multi, res_index}),
                        32'({1'b1, expHit, expMulti, expIdx}));
            @(negedge clk);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        #1;
        checkOutput("grant_after_res", 32'(srch_ready), 32'd1);
        modelSearch(8'h3C, 8'h00);
        lastGrantWasWrite = 1'b0;
        waitResult(0);

        // Reset while a write enable is on the array pins: the write is dropped.
        @(negedge clk);
        wr_valid = 1'b1; wr_addr = 3'd4; wr_data = 8'h99; wr_mask = 8'h00;
        #1;
        checkOutput("rstw_grant", 32'(wr_ready), 32'd1);
        @(negedge clk);
        wr_valid = 1'b0;
        checkOutput("rstw_we_pre", 32'(cam_we_row), 32'h10);
        rst = 1'b0;
        #1;
        checkOutput("rstw_we_drop", 32'(cam_we_row), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        modelReset();
        lastGrantWasWrite = 1'b0;

        // Reset during a search: no result appears, and the next search works.
        applyStimulus(1'b0, 3'd0, 8'hA5, 8'h00);
        @(negedge clk);
        srch_valid = 1'b0;
        rst = 1'b0;
        #1;
        checkOutput("rsts_res_valid", 32'(res_valid), 32'd0);
        checkOutput("rsts_we_row", 32'(cam_we_row), 32'd0);
        checkOutput("rsts_res_hit", 32'(res_hit), 32'd0);
        @(negedge clk);
        checkOutput("rsts_hold", 32'(res_valid), 32'd0);
        rst = 1'b1;
        modelReset();
        lastGrantWasWrite = 1'b0;
        applyStimulus(1'b0, 3'd0, 8'hA5, 8'h00);
        waitResult(1);
        applyStimulus(1'b1, 3'd3, 8'hA5, 8'h00);
        applyStimulus(1'b0, 3'd0, 8'hA5, 8'h00);
        waitResult(0);

        // Overwrite a row with an all-ones mask, then search its old value.
        applyStimulus(1'b1, 3'd1, 8'h11, 8'h00);
        applyStimulus(1'b1, 3'd1, 8'h11, 8'hFF);
        applyStimulus(1'b0, 3'd0, 8'h11, 8'h00);
        waitResult(0);

        // Randomized mix of writes and searches.
        for (int n = 0; n < 40; n++) begin
            rndData = dataTab[$urandom_range(0, 3)];
            rndSel  = $urandom_range(0, 9);
            if (rndSel == 0)     rndMask = 8'hFF;
            else if (rndSel < 3) rndMask = 8'($urandom) & 8'($urandom);
            else                 rndMask = 8'h00;
            if ($urandom_range(0, 1) == 1) begin
                applyStimulus(1'b1, 3'($urandom_range(0, 7)), rndData, rndMask);
            end else begin
                applyStimulus(1'b0, 3'd0, rndData, rndMask);
                waitResult($urandom_range(0, 3));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
